// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 convolutional encoder: codes one bit per accept, then appends
// K-1 zero tail symbols so the decoder's trellis terminates in the zero state.
module conv_encoder_framed #(
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter int             FRAME_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  input  logic       flush_i,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       sop_o,
  output logic       eof_o
);

  localparam int BIT_W  = $clog2(FRAME_LEN + 1);
  localparam int TAIL_W = $clog2(K);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_e;

  state_e              state_q, state_d;
  logic [K-2:0]        sr_q, sr_d;
  logic [BIT_W-1:0]    bit_ct_q, bit_ct_d;
  logic [TAIL_W-1:0]   tail_ct_q, tail_ct_d;
  logic                valid_q, valid_d;
  logic [1:0]          dout_q, dout_d;
  logic                sop_q, sop_d;
  logic                eof_q, eof_d;

  logic                accept;
  logic                code_bit;
  logic [K-1:0]        w;
  logic [1:0]          sym;

  assign ready_o  = (state_q != TAIL);
  assign accept   = enable_i & ready_o & ~flush_i;
  // Tail symbols always shift in zeros, whatever sits on d_in.
  assign code_bit = (state_q == TAIL) ? 1'b0 : d_in;
  assign w        = {code_bit, sr_q};
  assign sym      = {^(w & G0), ^(w & G1)};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    sr_d      = sr_q;
    bit_ct_d  = bit_ct_q;
    tail_ct_d = tail_ct_q;
    valid_d   = 1'b0;
    dout_d    = dout_q;
    sop_d     = 1'b0;
    eof_d     = 1'b0;

    unique case (state_q)
      IDLE: if (accept) begin
        valid_d   = 1'b1;
        sop_d     = 1'b1;
        bit_ct_d  = BIT_W'(1);
        tail_ct_d = '0;
        state_d   = (FRAME_LEN == 1) ? TAIL : DATA;
      end
      DATA: if (accept) begin
        valid_d  = 1'b1;
        bit_ct_d = bit_ct_q + BIT_W'(1);
        if (bit_ct_q == BIT_W'(FRAME_LEN - 1)) begin
          state_d   = TAIL;
          tail_ct_d = '0;
        end
      end
      TAIL: begin
        valid_d   = 1'b1;
        tail_ct_d = tail_ct_q + TAIL_W'(1);
        if (tail_ct_q == TAIL_W'(K - 2)) begin
          eof_d     = 1'b1;
          state_d   = IDLE;
          bit_ct_d  = '0;
          tail_ct_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_d) begin
      dout_d = sym;
      sr_d   = w[K-1:1];
    end

    // Abort wins over everything, including a bit offered in the same cycle.
    if (flush_i) begin
      state_d   = IDLE;
      sr_d      = '0;
      bit_ct_d  = '0;
      tail_ct_d = '0;
      valid_d   = 1'b0;
      sop_d     = 1'b0;
      eof_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_ct_q  <= '0;
      tail_ct_q <= '0;
      valid_q   <= 1'b0;
      dout_q    <= 2'b00;
      sop_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates from the same pre-edge values.
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_ct_q  <= bit_ct_d;
      tail_ct_q <= tail_ct_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      sop_q     <= sop_d;
      eof_q     <= eof_d;
    end
  end

  assign valid_o = valid_q;
  assign d_out   = dout_q;
  assign sop_o   = sop_q;
  assign eof_o   = eof_q;

endmodule

// File: doc/conv_encoder_framed.md
Name: conv_encoder_framed

Overview:
- Rate-1/2 convolutional encoder: the transmit end feeding the Viterbi decoder across the channel model.
- Accepts one information bit per handshake and emits a 2-bit coded symbol one cycle later.
- Groups bits into fixed-length frames and appends K-1 zero tail bits so the decoder sees a zero-terminated trellis.
- Exposes start/end markers for decoder traceback alignment.

Parameters:
- K, 3: constraint length; legal range 3..9.
- G0, 3'b111: generator polynomial for d_out[1], K bits; bit K-1 taps the current input.
- G1, 3'b101: generator polynomial for d_out[0], K bits.
- FRAME_LEN, 256: information bits per frame; must be at least 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- enable_i  input  1  input bit valid
- d_in  input  1  information bit
- flush_i  input  1  synchronous abort: drop the current frame and return to IDLE
- ready_o  output  1  encoder can accept d_in this cycle
- valid_o  output  1  d_out holds a coded symbol
- d_out  output  2  coded symbol; [1] = G0 parity, [0] = G1 parity
- sop_o  output  1  marks the first symbol of a frame
- eof_o  output  1  marks the last tail symbol of a frame

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sr=0, bit_ct=0, tail_ct=0.
  - valid_o=0, d_out=2'b00, sop_o=0, eof_o=0.
- Coding window and symbol:
  - sr is a K-1 bit shift register; sr[K-2] holds the most recent previous bit.
  - w = {b, sr[K-2:0]}, where b is the bit being coded.
  - d_out[1] = ^(w & G0); d_out[0] = ^(w & G1).
  - After coding, sr <= w[K-1:1].
- ready_o is combinational: 1 in IDLE and DATA, 0 in TAIL.
- accept = enable_i & ready_o & ~flush_i.
- Output timing: all outputs are registered, so latency is 1 cycle from accept to valid_o.
- FSM, IDLE:
  - On accept: code d_in, bit_ct<=1, sop_o<=1 next cycle.
  - Next state is DATA, or TAIL if FRAME_LEN==1.
- FSM, DATA:
  - On accept: code d_in, bit_ct++.
  - When the accepted bit is number FRAME_LEN: go to TAIL, tail_ct<=0.
  - Gaps are allowed: with enable_i=0, valid_o=0 next cycle, and sr and bit_ct hold.
- FSM, TAIL:
  - Every cycle, unconditionally, code b=0 and set valid_o=1; tail_ct++.
  - enable_i and d_in are ignored.
  - On the (K-1)th tail symbol: eof_o=1 with that symbol, next state IDLE, bit_ct=0. sr is all-zero by construction.
- Symbol spacing: tail symbols are back-to-back, K-1 consecutive valid cycles immediately following the last data symbol.
- Next-frame start: a new frame may start in the cycle state returns to IDLE, i.e. the cycle after the last tail symbol is registered.
- flush_i=1 in any state:
  - Next cycle: state=IDLE, sr=0, counters=0, valid_o=0, sop_o=0, eof_o=0.
  - flush_i overrides a simultaneous enable_i; that input bit is dropped.
- valid_o=0 cycles: d_out holds its last value; sop_o and eof_o are 0.
- sop_o and eof_o are single-cycle pulses, only ever asserted with valid_o=1.
- Counter widths: bit_ct is $clog2(FRAME_LEN+1) bits; tail_ct is $clog2(K) bits. Neither counter ever wraps.
- Reset asserted mid-frame: immediate return to reset values; a partial frame is never completed.

Test Plan:
1. Tail and sop/eof:
   - Setup: K=3, G0=7, G1=5, FRAME_LEN=4.
   - Stimulus: d_in 1,0,1,1 on consecutive cycles.
   - Response: d_out 11,10,00,01 then tail 01,11. valid_o high for 6 consecutive cycles; sop_o on symbol 1, eof_o on symbol 6. ready_o=0 for exactly 2 cycles.
2. Gapped input:
   - Stimulus: same bits with enable_i low for 3 cycles between each bit.
   - Response: identical symbol sequence 11,10,00,01,01,11. valid_o low during gaps. Tail still back-to-back.
3. All-zero frame:
   - Setup: FRAME_LEN=8.
   - Stimulus: d_in all 0.
   - Response: 10 symbols all 00; sop_o on the 1st, eof_o on the 10th.
4. Enable during TAIL:
   - Stimulus: enable_i=1, d_in=1 held continuously across a frame boundary.
   - Response: bits presented during TAIL are not consumed. The next frame's first symbol is 11 with sop_o, 1 cycle after eof_o.
5. Flush mid-frame:
   - Stimulus: assert flush_i together with enable_i after bit 2 of frame 1011.
   - Response: next cycle valid_o=0, ready_o=1, bit dropped. A new frame 1011 then produces 11,10,00,01,01,11 from zero state.
6. Async reset mid-tail:
   - Stimulus: pulse rst between two clock edges during TAIL.
   - Response: valid_o, d_out, sop_o, eof_o go to 0 without a clock edge. The next frame encodes from sr=0.
